// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the internal RAM access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    // Internal RAM map landmarks
    localparam logic [7:0] BIT_AREA_LO = 8'h20;
    localparam logic [7:0] BIT_AREA_HI = 8'h2F;
    localparam logic [7:0] SFR_BASE    = 8'h80;

    localparam int LOCK_MAX   = 4;
    localparam int LOCK_CNT_W = $clog2(LOCK_MAX);

endpackage

`default_nettype wire

// File: rtl/ram_access_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector; search begins at start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   start,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   win_idx,
    output logic               valid
);

    localparam logic [PTR_W:0] N_W = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        onehot  = '0;
        win_idx = '0;
        valid   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, start} + (PTR_W+1)'(k);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
                valid       = 1'b1;
                onehot[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_access_arbiter.sv
// ============================================================================
// Module      : ram_access_arbiter
// Description : Round-robin arbiter sequencing single-port internal RAM access.
//               Optional macro RAM_ARB_LOCK_EN adds locked back-to-back RMW.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
`ifdef RAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock,
`endif
    input  logic [NUM_REQ-1:0]        req,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [8*NUM_REQ-1:0]      req_wdata,
    input  logic [NUM_REQ-1:0]        req_is_bit,
    input  logic [8*NUM_REQ-1:0]      req_bit_addr,
    input  logic [NUM_REQ-1:0]        req_in_bit,
    input  logic [NUM_REQ-1:0]        req_indirect,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [7:0]                rdata,
    output logic                      rbit,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [7:0]                ram_in_data,
    output logic [7:0]                ram_bit_addr,
    output logic                      ram_rd,
    output logic                      ram_wr,
    output logic                      ram_is_bit,
    output logic                      ram_in_bit,
    output logic                      ram_indirect_flag,
    input  logic [7:0]                ram_out,
    input  logic                      ram_out_bit
);

    localparam int              PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    arb_state_t       state;
    logic [PTR_W-1:0] start_ptr;
    logic [PTR_W-1:0] owner;
    logic             cur_wr;

    logic [ADDR_W-1:0] addr_arr    [NUM_REQ];
    logic [7:0]        wdata_arr   [NUM_REQ];
    logic [7:0]        bitaddr_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]    = req_addr[ADDR_W*gi +: ADDR_W];
            assign wdata_arr[gi]   = req_wdata[8*gi +: 8];
            assign bitaddr_arr[gi] = req_bit_addr[8*gi +: 8];
        end
    endgenerate

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [PTR_W-1:0]   load_idx;

    // A requester whose done is high this cycle must not win again immediately
    assign eligible = req & ~done;
    assign load_idx = (state == CAPTURE) ? owner : pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req     (eligible),
        .start   (start_ptr),
        .onehot  (pick_onehot),
        .win_idx (pick_idx),
        .valid   (pick_valid)
    );

`ifdef RAM_ARB_LOCK_EN
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic                  relock;
    assign relock = lock[owner] && req[owner] &&
                    (lock_cnt < LOCK_CNT_W'(LOCK_MAX - 1));
`else
    logic relock;
    assign relock = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            start_ptr         <= '0;
            owner             <= '0;
            cur_wr            <= 1'b0;
            gnt               <= '0;
            done              <= '0;
            rdata             <= 8'h00;
            rbit              <= 1'b0;
            ram_addr          <= '0;
            ram_in_data       <= 8'h00;
            ram_bit_addr      <= 8'h00;
            ram_rd            <= 1'b0;
            ram_wr            <= 1'b0;
            ram_is_bit        <= 1'b0;
            ram_in_bit        <= 1'b0;
            ram_indirect_flag <= 1'b0;
`ifdef RAM_ARB_LOCK_EN
            lock_cnt          <= '0;
`endif
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        ram_addr          <= addr_arr[load_idx];
                        ram_in_data       <= wdata_arr[load_idx];
                        ram_bit_addr      <= bitaddr_arr[load_idx];
                        ram_is_bit        <= req_is_bit[load_idx];
                        ram_in_bit        <= req_in_bit[load_idx];
                        ram_indirect_flag <= req_indirect[load_idx];
                        cur_wr            <= req_wr[load_idx];
                        ram_rd            <= ~req_wr[load_idx];
                        ram_wr            <= req_wr[load_idx];
                        gnt               <= pick_onehot;
                        owner             <= pick_idx;
                        start_ptr         <= (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
                        state             <= ACCESS;
`ifdef RAM_ARB_LOCK_EN
                        lock_cnt          <= '0;
`endif
                    end
                end
                ACCESS: begin
                    ram_rd <= 1'b0;
                    ram_wr <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (!cur_wr) begin
                        rdata <= ram_out;
                        rbit  <= ram_out_bit;
                    end
                    done[owner] <= 1'b1;
                    if (relock) begin
                        ram_addr          <= addr_arr[load_idx];
                        ram_in_data       <= wdata_arr[load_idx];
                        ram_bit_addr      <= bitaddr_arr[load_idx];
                        ram_is_bit        <= req_is_bit[load_idx];
                        ram_in_bit        <= req_in_bit[load_idx];
                        ram_indirect_flag <= req_indirect[load_idx];
                        cur_wr            <= req_wr[load_idx];
                        ram_rd            <= ~req_wr[load_idx];
                        ram_wr            <= req_wr[load_idx];
                        state             <= ACCESS;
`ifdef RAM_ARB_LOCK_EN
                        lock_cnt          <= lock_cnt + 1'b1;
`endif
                    end else begin
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ram_rd <= 1'b0;
                    ram_wr <= 1'b0;
                    gnt    <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single-ported internal data RAM (lower RAM, SFR space, indirect upper RAM, bit-addressable space) between NUM_REQ requesters, e.g. CPU core, timer/serial SFR updater and debug port.
- Round-robin arbitration; sequences one RAM transaction at a time: grant, access, capture.
- Returns read byte/bit and a per-requester done pulse.
- Sits between requesters and the RAM; the only block that drives the RAM's rd/wr.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 8, RAM address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request level per requester.
- req_addr  in  8*NUM_REQ  byte address, slice i = [8i+7:8i].
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_wdata  in  8*NUM_REQ  write byte.
- req_is_bit  in  NUM_REQ  bit access.
- req_bit_addr  in  8*NUM_REQ  bit address.
- req_in_bit  in  NUM_REQ  bit write value.
- req_indirect  in  NUM_REQ  indirect access to 80h-FFh.
- gnt  out  NUM_REQ  one-hot; owner of the transaction in flight.
- done  out  NUM_REQ  one-cycle completion pulse.
- rdata  out  8  read byte, valid with done.
- rbit  out  1  read bit, valid with done.
- ram_addr, ram_in_data, ram_bit_addr  out  8 each  to RAM.
- ram_rd, ram_wr, ram_is_bit, ram_in_bit, ram_indirect_flag  out  1 each  to RAM.
- ram_out  in  8  RAM byte read data.
- ram_out_bit  in  1  RAM bit read data.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; gnt=0, done=0, rdata=00h, rbit=0.
  - All ram_* outputs 0; rr pointer = requester 0 highest priority.
  - Reset mid-transaction aborts it with no done pulse; the RAM sees no further strobe.
- FSM IDLE -> ACCESS -> CAPTURE -> IDLE.
- IDLE:
  - Eligible = req & ~done, so a requester is not re-granted in the cycle its done is high.
  - If any eligible: pick the round-robin winner, starting search at (last_winner+1) mod NUM_REQ.
  - At the edge: latch the winner's fields into ram_* registers, set gnt one-hot, pointer=winner, go to ACCESS.
- ACCESS, exactly one cycle:
  - ram_rd = ~latched_wr, ram_wr = latched_wr; both 0 in every other state.
  - RAM samples at the closing edge; go to CAPTURE.
- CAPTURE:
  - At the edge: read -> rdata<=ram_out, rbit<=ram_out_bit; write -> rdata/rbit hold.
  - done[winner]<=1 for one cycle, gnt<=0, go to IDLE.
- Latency: req sampled at edge E -> gnt high after E -> done high after E+2, i.e. 3 cycles. Throughput: one transaction per 3 cycles.
- Requester fields are latched at grant; the requester may change them once gnt is seen.
- A requester drops req on done; it keeps req high to queue another transaction.
- Dropping req after grant does not cancel the transaction.
- Fairness: a continuously requesting requester is granted within NUM_REQ transactions.
- ram_* outputs are registered, no combinational path from req to the RAM.
- When no transaction is in flight, ram_rd = ram_wr = 0 and the other ram_* outputs hold their last value.
- rr pointer arithmetic is mod NUM_REQ, wrapping NUM_REQ-1 -> 0.

Optional Feature:
- RAM_ARB_LOCK_EN, when defined:
  - Adds input lock[NUM_REQ].
  - If lock[winner] is high in CAPTURE and req[winner] is high, the arbiter re-latches that requester's current fields and goes CAPTURE -> ACCESS directly. done still pulses and gnt stays high.
  - This gives atomic read-modify-write, e.g. a SETB-style byte RMW.
  - The lock is held at most 4 consecutive transactions, then the requester is forced back through IDLE arbitration.
- Without the macro: no lock port; CAPTURE always returns to IDLE.

Decomposition:
- Package ram_arb_pkg:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, CAPTURE=2'd2.
  - RAM map constants: BIT_AREA_LO=8'h20, BIT_AREA_HI=8'h2F, SFR_BASE=8'h80.
  - LOCK_MAX=4.
- Sub-module rr_pick: combinational round-robin selector (req vector, pointer -> one-hot winner, valid).

Test Plan:
- Single read: req[0]=1, addr=30h, RAM holds 5Ah -> gnt=001 one cycle later, ram_rd one cycle in ACCESS, done[0] and rdata=5Ah 3 cycles after request.
- Write then readback: req[1] writes A5h to 90h, direct; then a read of 90h -> done[1] twice, second rdata=A5h; ram_wr high exactly one cycle.
- Contention: req=111 held continuously -> grant order 0,1,2,0,1,2; no requester granted twice before the others.
- Bit write: req[2], is_bit=1, addr=20h, bit_addr=09h, in_bit=1 -> subsequent byte read of 21h returns bit1 set.
- Reset mid-transaction: reset=0 during ACCESS -> gnt=0, done=0 immediately; after release, the first pending req is granted starting from requester 0.
- RAM_ARB_LOCK_EN: lock[0]=1 with req[0] and req[1] pending -> requester 0 gets 4 back-to-back transactions with no IDLE between, then requester 1 is granted.
